flash_line_arbiter: RTL and testbench
=====================================

Name: flash_line_arbiter

Overview:
- Shares one quad-I/O flash line reader between two line-fill requesters, e.g. the instruction-cache controller (port 0) and a data/prefetch cache controller (port 1).
- Sits between the requesters and the reader's addr/rd/done/line interface.
- Serialises line fetches with round-robin arbitration and broadcasts the returned line to the requesters.
- Completes a pending request for the same line in a single fetch (merge).

Parameters:
- LINE_SIZE, 128, line width in bits (128 or 256). OFS = log2(LINE_SIZE/8) low address bits are forced to zero on fr_addr.

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  asynchronous active-low reset
- m_req  in  2  per-requester fetch request, level; held until that requester's m_done
- m_addr0  in  24  port 0 byte address, stable while m_req[0]=1
- m_addr1  in  24  port 1 byte address, stable while m_req[1]=1
- m_gnt  out  2  one-hot current owner, level, valid in WAIT and RESP
- m_done  out  2  per-requester completion pulse, 1 cycle
- m_line  out  LINE_SIZE  registered line, valid when any m_done=1, held until the next capture
- busy  out  1  state != IDLE
- fr_addr  out  24  line-aligned address to reader, registered
- fr_rd  out  1  1-cycle read strobe to reader
- fr_done  in  1  reader completion pulse, 1 cycle
- fr_line  in  LINE_SIZE  reader data, valid with fr_done

Behaviour:
- Reset: HRESETn asynchronous, active-low; clock HCLK. On reset: state=IDLE, fr_rd=0, fr_addr=0, m_gnt=0, m_done=0, m_line=0, busy=0, rr_ptr=0, served mask=0. Reset mid-fetch abandons the fetch; any fr_done arriving afterwards in IDLE is ignored.
- States: IDLE, WAIT, RESP.
- IDLE:
  - eligible = m_req & ~served; served holds the m_done vector of the previous cycle and is cleared after one IDLE cycle.
  - With no eligible requester: remain in IDLE.
  - With one eligible requester: it wins.
  - With both eligible: the requester other than rr_ptr wins (rr_ptr = last winner).
  - On the winning cycle T: register owner, m_gnt, and fr_addr = {m_addrX[23:OFS], OFS'b0}. fr_rd=1 during cycle T+1 only. Go to WAIT.
- WAIT:
  - fr_addr and m_gnt are held.
  - fr_done in cycle D: m_line <= fr_line; compute merge. Go to RESP at D+1.
  - No timeout; WAIT lasts until fr_done.
- Merge: the other requester is merged when its m_req=1 and its aligned address equals fr_addr, sampled in cycle D.
- RESP: lasts exactly 1 cycle.
  - m_done[owner]=1 and m_done[other]=merge.
  - rr_ptr <= owner.
  - served <= m_done.
  - Next state is IDLE.
- Latency:
  - Request accepted in IDLE at T gives fr_rd at T+1.
  - fr_done at D gives m_done and m_line at D+1.
  - A back-to-back competing request gets fr_rd at RESP+2.
- fr_done outside WAIT is ignored. m_req changes during WAIT/RESP are ignored, except for the merge sample in cycle D.
- A requester that drops m_req early still receives m_done; the requester discards it.
- fr_rd is never asserted while state != IDLE at the previous edge, so at most one read is outstanding.
- m_done is never asserted to a requester whose m_req was 0 in cycle D, except the owner.

Test Plan:
- Reset, then m_req=01, m_addr0=0x00123C, fr_done 40 cycles after fr_rd → fr_rd 1 cycle with fr_addr=0x001230; m_done=01 one cycle after fr_done; m_line equals fr_line.
- Both requests in the same cycle, addr0=0x000100, addr1=0x004200, rr_ptr=0 after reset → port 1 wins first (fr_addr=0x004200), then port 0 (fr_addr=0x000100); fr_rd pulses spaced at least fetch+3 cycles apart.
- Merge: addr0=0x000104, addr1=0x00010C, both requesting → single fr_rd at 0x000100; m_done=11 together; no second fetch.
- Requester holds m_req one cycle past m_done → no re-grant; busy stays 0 afterwards.
- Spurious fr_done in IDLE → no state change, m_line unchanged, no m_done.
- Assert HRESETn=0 during WAIT, then release, then fr_done → all outputs at reset values; fr_done ignored; a new request is served normally.
- LINE_SIZE=256: addr=0x00ABCD → fr_addr=0x00ABC0.

Source files
------------

// File: rtl/flash_line_arbiter.sv
// Round-robin arbiter sharing one flash line reader between two line-fill requesters.
// Returned lines are broadcast; a pending request for the same line completes in the same fetch.
module flash_line_arbiter #(
  parameter int LINE_SIZE = 128
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [1:0]           m_req,
  input  logic [23:0]          m_addr0,
  input  logic [23:0]          m_addr1,
  output logic [1:0]           m_gnt,
  output logic [1:0]           m_done,
  output logic [LINE_SIZE-1:0] m_line,
  output logic                 busy,
  output logic [23:0]          fr_addr,
  output logic                 fr_rd,
  input  logic                 fr_done,
  input  logic [LINE_SIZE-1:0] fr_line
);

  localparam int          OFS        = $clog2(LINE_SIZE / 8);
  localparam logic [23:0] ALIGN_MASK = ~((24'd1 << OFS) - 24'd1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Handshake: m_req is a level held until m_done; m_done and fr_rd are single-cycle
  // pulses; fr_done is accepted only in WAIT, so at most one read is ever outstanding.
  logic [1:0]           state_q, state_d;
  logic                 owner_q, owner_d;
  logic [1:0]           gnt_q, gnt_d;
  logic [23:0]          addr_q, addr_d;
  logic                 rd_q, rd_d;
  logic [1:0]           done_q, done_d;
  logic [LINE_SIZE-1:0] line_q, line_d;
  logic                 rr_q, rr_d;
  logic [1:0]           served_q, served_d;

  logic [1:0]  eligible;
  logic        win;
  logic        other_req;
  logic [23:0] other_addr;
  logic        merge;

  assign eligible   = m_req & ~served_q;
  // On a tie the requester that did not win last time goes next.
  assign win        = (eligible == 2'b11) ? ~rr_q : eligible[1];
  assign other_req  = owner_q ? m_req[0] : m_req[1];
  assign other_addr = owner_q ? m_addr0 : m_addr1;
  assign merge      = other_req && ((other_addr & ALIGN_MASK) == addr_q);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    gnt_d    = gnt_q;
    addr_d   = addr_q;
    rd_d     = 1'b0;
    done_d   = 2'b00;
    line_d   = line_q;
    rr_d     = rr_q;
    served_d = served_q;
    case (state_q)
      S_IDLE: begin
        served_d = 2'b00;
        if (|eligible) begin
          owner_d = win;
          gnt_d   = win ? 2'b10 : 2'b01;
          addr_d  = (win ? m_addr1 : m_addr0) & ALIGN_MASK;
          rd_d    = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (fr_done) begin
          line_d  = fr_line;
          done_d  = owner_q ? {1'b1, merge} : {merge, 1'b1};
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        rr_d     = owner_q;
        served_d = done_q;
        gnt_d    = 2'b00;
        state_d  = S_IDLE;
      end
      default: begin
        gnt_d   = 2'b00;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      gnt_q    <= 2'b00;
      addr_q   <= 24'd0;
      rd_q     <= 1'b0;
      done_q   <= 2'b00;
      line_q   <= '0;
      rr_q     <= 1'b0;
      served_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      gnt_q    <= gnt_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      done_q   <= done_d;
      line_q   <= line_d;
      rr_q     <= rr_d;
      served_q <= served_d;
    end
  end

  assign m_gnt   = gnt_q;
  assign m_done  = done_q;
  assign m_line  = line_q;
  assign busy    = (state_q != S_IDLE);
  assign fr_addr = addr_q;
  assign fr_rd   = rd_q;

endmodule

// File: tb/tb_flash_line_arbiter.sv
// Bench for flash_line_arbiter: directed vectors, expected reads and completions
// are queued at issue time and checked by an independent monitor.
module tb_flash_line_arbiter;

  logic         HCLK = 1'b0;
  logic         HRESETn;
  logic [1:0]   m_req;
  logic [23:0]  m_addr0, m_addr1;
  logic [1:0]   m_gnt, m_done;
  logic [127:0] m_line;
  logic         busy;
  logic [23:0]  fr_addr;
  logic         fr_rd;
  logic         fr_done;
  logic [127:0] fr_line;

  logic [1:0]   b_req;
  logic [23:0]  b_addr0, b_addr1;
  logic [1:0]   b_gnt, b_done;
  logic [255:0] b_line;
  logic         b_busy;
  logic [23:0]  b_fr_addr;
  logic         b_fr_rd;
  logic         b_fr_done;
  logic [255:0] b_fr_line;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [23:0]  addr_exp_q[$];
  logic [1:0]   done_exp_q[$];
  logic [127:0] line_exp_q[$];

  localparam logic [127:0] L1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] L2 = 128'hA5A5_0001_A5A5_0002_A5A5_0003_A5A5_0004;
  localparam logic [127:0] L3 = 128'h0F0F_F0F0_DEAD_BEEF_CAFE_F00D_1234_5678;
  localparam logic [127:0] L4 = 128'h8765_4321_0FED_CBA9_8765_4321_0FED_CBA9;
  localparam logic [127:0] L5 = 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA;
  localparam logic [127:0] L6 = 128'h0000_0000_FFFF_FFFF_0123_4567_89AB_CDEF;
  localparam logic [127:0] LJ = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
  localparam logic [255:0] LB = {L3, L6};

  flash_line_arbiter #(.LINE_SIZE(128)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .m_req(m_req), .m_addr0(m_addr0), .m_addr1(m_addr1),
    .m_gnt(m_gnt), .m_done(m_done), .m_line(m_line), .busy(busy), .fr_addr(fr_addr),
    .fr_rd(fr_rd), .fr_done(fr_done), .fr_line(fr_line)
  );

  flash_line_arbiter #(.LINE_SIZE(256)) dut256 (
    .HCLK(HCLK), .HRESETn(HRESETn), .m_req(b_req), .m_addr0(b_addr0), .m_addr1(b_addr1),
    .m_gnt(b_gnt), .m_done(b_done), .m_line(b_line), .busy(b_busy), .fr_addr(b_fr_addr),
    .fr_rd(b_fr_rd), .fr_done(b_fr_done), .fr_line(b_fr_line)
  );

  // Clock and cycle counter
  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  initial begin
    forever begin
      @(negedge HCLK);
      if (fr_rd) begin
        if (addr_exp_q.size() == 0) check("fr_rd unexpected", fr_rd, 1'b0);
        else check("fr_addr", fr_addr, addr_exp_q.pop_front());
      end
      if (m_done != 2'b00) begin
        if (done_exp_q.size() == 0) check("m_done unexpected", m_done, 2'b00);
        else begin
          check("m_done", m_done, done_exp_q.pop_front());
          check("m_line", m_line, line_exp_q.pop_front());
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic wait_rd(output int at);
    at = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge HCLK);
      if (fr_rd) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check("fr_rd timeout", fr_rd, 1'b1);
  endtask

  task automatic reader(input int dly, input logic [127:0] line);
    repeat (dly) @(posedge HCLK);
    #1;
    fr_done = 1'b1;
    fr_line = line;
    tick();
    fr_done = 1'b0;
  endtask

  task automatic wait_done(output logic [1:0] v);
    v = 2'b00;
    for (int i = 0; i < 200; i++) begin
      @(negedge HCLK);
      if (m_done != 2'b00) begin
        v = m_done;
        break;
      end
    end
    if (v == 2'b00) check("m_done timeout", |m_done, 1'b1);
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: simulation exceeded time limit");
    summary();
    $finish;
  end

  initial begin
    int          a1, a2;
    logic [1:0]  dv;
    logic        bz;
    logic        seen;

    HRESETn = 1'b0; m_req = 2'b00; m_addr0 = '0; m_addr1 = '0;
    fr_done = 1'b0; fr_line = '0;
    b_req = 2'b00; b_addr0 = '0; b_addr1 = '0; b_fr_done = 1'b0; b_fr_line = '0;
    repeat (3) tick();
    @(negedge HCLK);
    check("rst busy", busy, 1'b0);
    check("rst fr_rd", fr_rd, 1'b0);
    check("rst fr_addr", fr_addr, 24'd0);
    check("rst m_gnt", m_gnt, 2'b00);
    check("rst m_line", m_line, 128'd0);
    tick();
    HRESETn = 1'b1;
    tick();

    // Single request on port 0, slow reader
    addr_exp_q.push_back(24'h001230); done_exp_q.push_back(2'b01); line_exp_q.push_back(L1);
    m_addr0 = 24'h00123C; m_req = 2'b01;
    wait_rd(a1);
    check("t1 m_gnt", m_gnt, 2'b01);
    check("t1 busy", busy, 1'b1);
    reader(40, L1);
    wait_done(dv);
    tick(); m_req = 2'b00;

    // Simultaneous requests: port 1 first after reset, then port 0
    addr_exp_q.push_back(24'h004200); done_exp_q.push_back(2'b10); line_exp_q.push_back(L2);
    addr_exp_q.push_back(24'h000100); done_exp_q.push_back(2'b01); line_exp_q.push_back(L4);
    repeat (2) tick();
    m_addr0 = 24'h000100; m_addr1 = 24'h004200; m_req = 2'b11;
    wait_rd(a1);
    check("t2 m_gnt first", m_gnt, 2'b10);
    reader(5, L2);
    wait_done(dv);
    tick(); m_req = 2'b01;
    wait_rd(a2);
    check("t2 m_gnt second", m_gnt, 2'b01);
    check("t2 rd spacing", a2 - a1, 5 + 3);
    reader(7, L4);
    wait_done(dv);
    tick(); m_req = 2'b00;

    // Same-line merge: one fetch completes both
    addr_exp_q.push_back(24'h000100); done_exp_q.push_back(2'b11); line_exp_q.push_back(L3);
    repeat (2) tick();
    m_addr0 = 24'h000104; m_addr1 = 24'h00010C; m_req = 2'b11;
    wait_rd(a1);
    check("t3 m_gnt", m_gnt, 2'b10);
    reader(3, L3);
    wait_done(dv);
    tick(); m_req = 2'b00;
    repeat (10) @(negedge HCLK);
    check("t3 busy idle", busy, 1'b0);

    // Owner holds m_req one cycle past m_done
    addr_exp_q.push_back(24'h000200); done_exp_q.push_back(2'b01); line_exp_q.push_back(L5);
    tick();
    m_addr0 = 24'h000207; m_req = 2'b01;
    wait_rd(a1);
    reader(2, L5);
    wait_done(dv);
    tick();
    tick(); m_req = 2'b00;
    bz = 1'b0;
    repeat (5) begin
      @(negedge HCLK);
      bz = bz | busy;
    end
    check("t4 busy after hold", bz, 1'b0);

    // Spurious fr_done in IDLE
    tick();
    fr_done = 1'b1; fr_line = LJ;
    tick();
    fr_done = 1'b0;
    @(negedge HCLK);
    check("t5 busy", busy, 1'b0);
    check("t5 m_line kept", m_line, L5);
    repeat (3) @(negedge HCLK);

    // Reset during WAIT abandons the fetch
    addr_exp_q.push_back(24'h000300);
    tick();
    m_addr0 = 24'h000300; m_req = 2'b01;
    wait_rd(a1);
    repeat (3) tick();
    HRESETn = 1'b0; m_req = 2'b00;
    @(negedge HCLK);
    check("t6 rst busy", busy, 1'b0);
    check("t6 rst fr_addr", fr_addr, 24'd0);
    check("t6 rst m_gnt", m_gnt, 2'b00);
    check("t6 rst m_done", m_done, 2'b00);
    check("t6 rst m_line", m_line, 128'd0);
    tick(); HRESETn = 1'b1;
    tick();
    fr_done = 1'b1; fr_line = LJ;
    tick();
    fr_done = 1'b0;
    @(negedge HCLK);
    check("t6 late fr_done busy", busy, 1'b0);
    check("t6 late fr_done m_line", m_line, 128'd0);
    addr_exp_q.push_back(24'h000450); done_exp_q.push_back(2'b10); line_exp_q.push_back(L6);
    tick();
    m_addr1 = 24'h00045A; m_req = 2'b10;
    wait_rd(a1);
    check("t6 m_gnt", m_gnt, 2'b10);
    reader(4, L6);
    wait_done(dv);
    tick(); m_req = 2'b00;

    // 256-bit line instance
    b_addr0 = 24'h00ABCD; b_req = 2'b01;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge HCLK);
      if (b_fr_rd) begin
        seen = 1'b1;
        break;
      end
    end
    check("t7 fr_rd seen", seen, 1'b1);
    check("t7 fr_addr", b_fr_addr, 24'h00ABC0);
    repeat (3) tick();
    b_fr_done = 1'b1; b_fr_line = LB;
    tick();
    b_fr_done = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge HCLK);
      if (b_done != 2'b00) begin
        seen = 1'b1;
        break;
      end
    end
    check("t7 m_done", b_done, 2'b01);
    check("t7 m_line", b_line, LB);
    tick(); b_req = 2'b00;

    repeat (5) tick();
    check("addr queue drained", addr_exp_q.size(), 0);
    check("done queue drained", done_exp_q.size(), 0);
    summary();
    $finish;
  end

endmodule
